// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//
// Iterative integer multiply / divide unit. One request at a time. It runs a
// radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop over
// the operand magnitudes for WIDTH cycles. It then spends one cycle fixing up
// the signs and holds the result until the consumer takes it.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high reset
//   in_valid   : request present
//   in_ready   : unit is idle and can accept a request
//   in_op      : 000 imul, 001 mul, 010 idiv, 011 div, 1xx reserved
//   in_a       : multiplicand / dividend
//   in_b       : multiplier / divisor
//   in_tag     : opaque tag returned with the result
//   out_valid  : result present
//   out_ready  : consumer accepts the result
//   out_lo     : low product half or quotient
//   out_hi     : high product half or remainder
//   out_cf     : carry flag (product does not fit in out_lo)
//   out_of     : overflow flag (same as out_cf)
//   out_de     : divide error or reserved opcode
//   out_tag    : tag of the request that produced the result
// All out_* data signals are forced to zero while out_valid is low.
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             out_cf,
    output logic             out_of,
    output logic             out_de,
    output logic [TAG_W-1:0] out_tag
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [1:0]         op_q,      op_d;       // [1]: divide, [0]: unsigned
    logic [TAG_W-1:0]   tag_q,     tag_d;
    logic [WIDTH-1:0]   mag_q,     mag_d;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   hi_q,      hi_d;       // partial product high / remainder
    logic [WIDTH-1:0]   lo_q,      lo_d;       // multiplier bits / dividend->quotient
    logic               neg_res_q, neg_res_d;  // product or quotient is negative
    logic               neg_rem_q, neg_rem_d;  // remainder takes dividend sign
    logic               err_q,     err_d;
    logic               flag_q,    flag_d;
    logic               de_q,      de_d;

    // ---------------------------------------------------------------- request
    logic               in_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               req_err;

    assign in_signed = ~in_op[0];
    assign a_neg     = in_signed & in_a[WIDTH-1];
    assign b_neg     = in_signed & in_b[WIDTH-1];
    // The most negative value maps to itself, which is the correct unsigned
    // magnitude 2^(WIDTH-1).
    assign abs_a     = a_neg ? -in_a : in_a;
    assign abs_b     = b_neg ? -in_b : in_b;
    assign req_err   = in_op[2]
                     | (in_op[1] & (in_b == '0))
                     | ((in_op == 3'b010) && (in_a == MOST_NEG) && (in_b == '1));

    // -------------------------------------------------------------- iteration
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    // Multiply: conditionally add the multiplicand, then shift {hi,lo} right.
    assign add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    // Divide: shift the next dividend bit into the remainder, and subtract when
    // it fits. When it fits the true difference is below mag_q, so WIDTH bits
    // hold it exactly.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_q});
    assign div_diff  = div_shift[WIDTH-1:0] - mag_q;

    // ---------------------------------------------------------------- fix-up
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   prod_hi;
    logic [WIDTH-1:0]   prod_lo;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               mul_flag;

    assign prod_mag = {hi_q, lo_q};
    assign prod_fix = neg_res_q ? -prod_mag : prod_mag;
    assign prod_hi  = prod_fix[2*WIDTH-1:WIDTH];
    assign prod_lo  = prod_fix[WIDTH-1:0];
    assign mul_flag = op_q[0] ? (prod_hi != '0)
                              : (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});
    assign quo_fix  = neg_res_q ? -lo_q : lo_q;
    assign rem_fix  = neg_rem_q ? -hi_q : hi_q;

    // ------------------------------------------------------------ next state
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        tag_d     = tag_q;
        mag_d     = mag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        err_d     = err_q;
        flag_d    = flag_q;
        de_d      = de_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = BUSY;
                    cnt_d     = '0;
                    op_d      = in_op[1:0];
                    tag_d     = in_tag;
                    err_d     = req_err;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    hi_d      = '0;
                    flag_d    = 1'b0;
                    de_d      = 1'b0;
                    if (in_op[1]) begin
                        mag_d = abs_b;
                        lo_d  = abs_a;
                    end else begin
                        mag_d = abs_a;
                        lo_d  = abs_b;
                    end
                end
            end

            BUSY: begin
                if (err_q) begin
                    // Error requests skip the iteration and leave BUSY after a
                    // single cycle, so the result appears one cycle after accept.
                    state_d = DONE;
                    hi_d    = '0;
                    lo_d    = '0;
                    flag_d  = 1'b0;
                    de_d    = 1'b1;
                end else if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    if (op_q[1]) begin
                        lo_d   = quo_fix;
                        hi_d   = rem_fix;
                        flag_d = 1'b0;
                    end else begin
                        lo_d   = prod_lo;
                        hi_d   = prod_hi;
                        flag_d = mul_flag;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (op_q[1]) begin
                        hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        hi_d = add_sum[WIDTH:1];
                        lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            mag_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            err_q     <= 1'b0;
            flag_q    <= 1'b0;
            de_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            mag_q     <= mag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            err_q     <= err_d;
            flag_q    <= flag_d;
            de_q      <= de_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_lo    = out_valid ? lo_q  : '0;
    assign out_hi    = out_valid ? hi_q  : '0;
    assign out_tag   = out_valid ? tag_q : '0;
    assign out_cf    = out_valid & flag_q;
    assign out_of    = out_valid & flag_q;
    assign out_de    = out_valid & de_q;

endmodule
